// File: rtl/i2c_passthru_port_arb.sv
// Round-robin arbiter sharing one i2c passthru across N channel-B ports.
// The passthru is held disconnected for one t_buf after every select change and is released only on bus idle.
module i2c_passthru_port_arb #(
    parameter int N_PORTS                     = 4,
    parameter int WIDTH_PORT                  = $clog2(N_PORTS),
    parameter int F_REF_T_BUF                 = 38,
    parameter int WIDTH_F_REF_T_BUF           = $clog2(F_REF_T_BUF + 1),
    parameter int F_REF_SLOW_T_HOLD_MAX       = 255,
    parameter int WIDTH_F_REF_SLOW_T_HOLD_MAX = $clog2(F_REF_SLOW_T_HOLD_MAX + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_f_ref,
    input  logic                  i_f_ref_slow,
    input  logic [N_PORTS-1:0]    i_req,
    input  logic                  i_bus_idle,
    input  logic                  i_stuck,
    output logic [WIDTH_PORT-1:0] o_sel,
    output logic                  o_connect,
    output logic [N_PORTS-1:0]    o_gnt,
    output logic                  o_busy,
    output logic                  o_hold_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CONNECTED,
        DRAIN
    } state_t;

    localparam logic [WIDTH_F_REF_T_BUF-1:0] T_BUF_DONE = WIDTH_F_REF_T_BUF'(F_REF_T_BUF);
    localparam logic [WIDTH_F_REF_T_BUF-1:0] T_BUF_ONE  = WIDTH_F_REF_T_BUF'(1);
    localparam logic [WIDTH_F_REF_SLOW_T_HOLD_MAX-1:0] HOLD_MAX =
        WIDTH_F_REF_SLOW_T_HOLD_MAX'(F_REF_SLOW_T_HOLD_MAX);
    localparam logic [WIDTH_F_REF_SLOW_T_HOLD_MAX-1:0] HOLD_ONE = WIDTH_F_REF_SLOW_T_HOLD_MAX'(1);
    localparam logic [N_PORTS-1:0]    PORT0_ONEHOT = N_PORTS'(1);
    localparam logic [WIDTH_PORT-1:0] RR_RESET     = WIDTH_PORT'(N_PORTS - 1);

    state_t                                 state_q, state_d;
    logic [WIDTH_PORT-1:0]                  sel_q, sel_d;
    logic [WIDTH_PORT-1:0]                  rr_q, rr_d;
    logic [WIDTH_F_REF_T_BUF-1:0]           tbuf_q, tbuf_d;
    logic [WIDTH_F_REF_SLOW_T_HOLD_MAX-1:0] hold_q, hold_d;
    logic                                   connect_q, connect_d;
    logic [N_PORTS-1:0]                     gnt_q, gnt_d;
    logic                                   busy_q, busy_d;
    logic                                   timeout_q, timeout_d;
    logic                                   f_ref_prev, f_ref_slow_prev;

    logic                     f_ref_tick, f_ref_slow_tick;
    logic [N_PORTS-1:0]       sel_onehot;
    logic                     sel_req, others_req;
    logic [2*N_PORTS-1:0]     req_rot;
    logic [WIDTH_PORT-1:0]    pick;
    logic                     pick_valid;

    assign f_ref_tick      = i_f_ref & ~f_ref_prev;
    assign f_ref_slow_tick = i_f_ref_slow & ~f_ref_slow_prev;
    assign sel_onehot      = PORT0_ONEHOT << sel_q;
    assign sel_req         = |(i_req & sel_onehot);
    assign others_req      = |(i_req & ~sel_onehot);

    // Rotate the doubled request vector so the port after rr_q lands at bit 0, then take the lowest set bit.
    always_comb begin
        int first;
        req_rot    = {i_req, i_req} >> (int'(rr_q) + 1);
        pick_valid = |i_req;
        first      = 0;
        for (int j = N_PORTS - 1; j >= 0; j--) begin
            if (req_rot[j]) first = j;
        end
        first = first + int'(rr_q) + 1;
        if (first >= N_PORTS) first = first - N_PORTS;
        pick = WIDTH_PORT'(first);
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        tbuf_d    = tbuf_q;
        hold_d    = hold_q;
        connect_d = connect_q;
        gnt_d     = '0;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                connect_d = 1'b0;
                if (!i_stuck && pick_valid) begin
                    sel_d   = pick;
                    tbuf_d  = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                connect_d = 1'b0;
                if (!sel_req) begin
                    tbuf_d  = '0;
                    state_d = IDLE;
                end else if (tbuf_q == T_BUF_DONE) begin
                    state_d   = CONNECTED;
                    connect_d = 1'b1;
                    gnt_d     = sel_onehot;
                    rr_d      = sel_q;
                    hold_d    = '0;
                end else if (f_ref_tick) begin
                    tbuf_d = tbuf_q + T_BUF_ONE;
                end
            end
            CONNECTED: begin
                gnt_d = sel_onehot;
                if (f_ref_slow_tick && hold_q != HOLD_MAX) hold_d = hold_q + HOLD_ONE;
                // A voluntary release wins over preemption, so no timeout pulse in that case.
                if (!sel_req) begin
                    state_d = DRAIN;
                    gnt_d   = '0;
                end else if (hold_q == HOLD_MAX && others_req) begin
                    state_d   = DRAIN;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            DRAIN: begin
                if (i_bus_idle) begin
                    state_d   = IDLE;
                    connect_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_stuck && state_q != IDLE) begin
            state_d   = IDLE;
            connect_d = 1'b0;
            gnt_d     = '0;
            timeout_d = 1'b0;
            tbuf_d    = '0;
            hold_d    = '0;
        end
    end

    assign busy_d = (state_d != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= IDLE;
            sel_q           <= '0;
            rr_q            <= RR_RESET;
            tbuf_q          <= '0;
            hold_q          <= '0;
            connect_q       <= 1'b0;
            gnt_q           <= '0;
            busy_q          <= 1'b0;
            timeout_q       <= 1'b0;
            // Preset high so a reference already high out of reset is not taken as an edge.
            f_ref_prev      <= 1'b1;
            f_ref_slow_prev <= 1'b1;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            rr_q            <= rr_d;
            tbuf_q          <= tbuf_d;
            hold_q          <= hold_d;
            connect_q       <= connect_d;
            gnt_q           <= gnt_d;
            busy_q          <= busy_d;
            timeout_q       <= timeout_d;
            f_ref_prev      <= i_f_ref;
            f_ref_slow_prev <= i_f_ref_slow;
        end
    end

    assign o_sel          = sel_q;
    assign o_connect      = connect_q;
    assign o_gnt          = gnt_q;
    assign o_busy         = busy_q;
    assign o_hold_timeout = timeout_q;

endmodule

// File: tb/tb_i2c_passthru_port_arb.sv
// Self-checking bench for i2c_passthru_port_arb: directed scenarios plus randomized arbitration
// checked against a round-robin reference kept as a "last granted port" integer.
module tb_i2c_passthru_port_arb;

    localparam int N      = 4;
    localparam int WP     = 2;
    localparam int T_BUF  = 38;
    localparam int T_HOLD = 255;
    localparam logic [N-1:0] ALL_REQ = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          f_ref = 1'b0;
    logic          f_ref_slow = 1'b0;
    logic [N-1:0]  req = '0;
    logic          bus_idle = 1'b1;
    logic          stuck = 1'b0;
    logic [WP-1:0] sel;
    logic          connect;
    logic [N-1:0]  gnt;
    logic          busy;
    logic          hold_timeout;

    int checks = 0;
    int failures = 0;
    int last = N - 1;
    bit fref_en = 1'b1;
    bit slow_en = 1'b0;
    int fref_rises = 0;
    int slow_rises = 0;

    i2c_passthru_port_arb dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_f_ref       (f_ref),
        .i_f_ref_slow  (f_ref_slow),
        .i_req         (req),
        .i_bus_idle    (bus_idle),
        .i_stuck       (stuck),
        .o_sel         (sel),
        .o_connect     (connect),
        .o_gnt         (gnt),
        .o_busy        (busy),
        .o_hold_timeout(hold_timeout)
    );

    always #5 clk = ~clk;

    // Reference clocks change on the falling edge; the bench counts the rising edges it produced.
    initial begin
        forever begin
            repeat (4) @(negedge clk);
            if (fref_en) begin
                f_ref = ~f_ref;
                if (f_ref) fref_rises++;
            end
        end
    end

    initial begin
        forever begin
            repeat (2) @(negedge clk);
            if (slow_en) begin
                f_ref_slow = ~f_ref_slow;
                if (f_ref_slow) slow_rises++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester strictly after the last granted port, wrapping.
    function automatic int rr_pick(input int prev, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(prev + k) % N]) return (prev + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int p);
        logic [N-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    // Structural invariants every cycle.
    initial begin
        logic          prev_connect;
        logic [WP-1:0] prev_sel;
        prev_connect = 1'b0;
        prev_sel     = '0;
        forever begin
            @(negedge clk);
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("sel_in_range", 32'(int'(sel) < N), 32'd1);
            if (gnt != '0) check("gnt_needs_connect", 32'(connect), 32'd1);
            if (prev_connect && connect) check("sel_stable_connected", 32'(sel), 32'(prev_sel));
            prev_connect = connect;
            prev_sel     = sel;
        end
    end

    initial begin
        int p, q, exp_port, base;
        logic [N-1:0] mask;
        bit ok;

        // Reset values.
        rst = 1'b1;
        repeat (3) step();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_connect", 32'(connect), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(hold_timeout), 32'd0);
        rst = 1'b0;
        bus_idle = 1'b0;
        step();

        // Single request: select in one cycle, connect after exactly t_buf f_ref edges.
        p = $urandom_range(1, N - 1);
        req = onehot(p);
        step();
        check("single_sel", 32'(sel), 32'(p));
        check("single_busy", 32'(busy), 32'd1);
        check("single_connect_low", 32'(connect), 32'd0);
        base = fref_rises;
        wait_gnt("single_gnt_timeout");
        check("single_tbuf_edges", 32'(fref_rises - base), 32'(T_BUF));
        check("single_gnt", 32'(gnt), 32'(onehot(p)));
        check("single_connect", 32'(connect), 32'd1);
        last = p;
        req = '0;
        repeat (2) step();
        check("drain_connect", 32'(connect), 32'd1);
        check("drain_gnt", 32'(gnt), 32'd0);
        check("drain_sel", 32'(sel), 32'(p));
        check("drain_busy", 32'(busy), 32'd1);
        bus_idle = 1'b1;
        step();
        check("release_busy", 32'(busy), 32'd0);
        check("release_connect", 32'(connect), 32'd0);

        // Randomized request masks against the round-robin reference.
        for (int t = 0; t < 8; t++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            exp_port = rr_pick(last, mask);
            req = mask;
            step();
            check("rand_sel", 32'(sel), 32'(exp_port));
            base = fref_rises;
            wait_gnt("rand_gnt_timeout");
            check("rand_gnt", 32'(gnt), 32'(onehot(exp_port)));
            check("rand_tbuf_edges", 32'(fref_rises - base), 32'(T_BUF));
            last = exp_port;
            req = '0;
            bus_idle = 1'($urandom_range(0, 1));
            if (!bus_idle) begin
                repeat ($urandom_range(2, 5)) step();
                check("rand_drain_hold", 32'({connect, gnt}), 32'({1'b1, {N{1'b0}}}));
                bus_idle = 1'b1;
            end
            wait_idle("rand_idle_timeout");
        end

        // All ports requesting: holder drops and re-asserts during DRAIN, order rotates.
        req = ALL_REQ;
        for (int t = 0; t < 5; t++) begin
            exp_port = rr_pick(last, ALL_REQ);
            wait_gnt("rr_gnt_timeout");
            check("rr_order", 32'(gnt), 32'(onehot(exp_port)));
            last = exp_port;
            req[exp_port] = 1'b0;
            step();
            req = ALL_REQ;
            step();
        end
        req = '0;
        wait_idle("rr_idle_timeout");

        // Preemption: port 2 holds while port 0 waits for the full hold time.
        req = onehot(2);
        wait_gnt("pre_gnt2_timeout");
        check("pre_gnt2", 32'(gnt), 32'(onehot(2)));
        last = 2;
        bus_idle = 1'b0;
        req = onehot(0) | onehot(2);
        base = slow_rises;
        slow_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (hold_timeout) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("pre_timeout_seen", 32'(ok), 32'd1);
        check("pre_slow_edges", 32'(slow_rises - base), 32'(T_HOLD));
        check("pre_gnt_zero", 32'(gnt), 32'd0);
        check("pre_connect", 32'(connect), 32'd1);
        check("pre_sel", 32'(sel), 32'd2);
        slow_en = 1'b0;
        step();
        check("pre_pulse_single", 32'(hold_timeout), 32'd0);
        repeat (3) step();
        check("pre_wait_sel", 32'(sel), 32'd2);
        check("pre_wait_connect", 32'(connect), 32'd1);
        bus_idle = 1'b1;
        exp_port = rr_pick(last, req);
        wait_gnt("pre_next_timeout");
        check("pre_next_gnt", 32'(gnt), 32'(onehot(exp_port)));
        last = exp_port;
        req = '0;
        wait_idle("pre_idle_timeout");

        // Abort in SETTLE must leave the round-robin pointer untouched.
        p = (last + 2) % N;
        q = (p + 1) % N;
        req = onehot(p);
        step();
        check("abort_sel", 32'(sel), 32'(p));
        base = fref_rises;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (fref_rises - base >= 10) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("abort_edges_timeout", 32'(ok), 32'd1);
        check("abort_connect_low", 32'(connect), 32'd0);
        req = '0;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_connect", 32'(connect), 32'd0);
        mask = onehot(p) | onehot(q);
        exp_port = rr_pick(last, mask);
        req = mask;
        wait_gnt("abort_next_timeout");
        check("abort_next_gnt", 32'(gnt), 32'(onehot(exp_port)));
        last = exp_port;

        // Stuck while connected: immediate return to IDLE without waiting for bus idle.
        bus_idle = 1'b0;
        stuck = 1'b1;
        step();
        stuck = 1'b0;
        check("stuck_connect", 32'(connect), 32'd0);
        check("stuck_gnt", 32'(gnt), 32'd0);
        check("stuck_busy", 32'(busy), 32'd0);
        req = '0;
        bus_idle = 1'b1;
        step();
        check("stuck_stays_idle", 32'(busy), 32'd0);

        // Reset in the middle of DRAIN restores the round-robin pointer to the last port.
        p = $urandom_range(0, N - 2);
        req = onehot(p);
        wait_gnt("rstd_gnt_timeout");
        bus_idle = 1'b0;
        req = '0;
        repeat (2) step();
        check("rstd_in_drain", 32'({busy, connect, gnt}), 32'({2'b11, {N{1'b0}}}));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstd_outputs", 32'({sel, connect, gnt, busy, hold_timeout}), 32'd0);
        last = N - 1;
        bus_idle = 1'b1;
        req = ALL_REQ;
        exp_port = rr_pick(last, ALL_REQ);
        step();
        check("rstd_sel", 32'(sel), 32'(exp_port));
        wait_gnt("rstd_next_timeout");
        check("rstd_gnt", 32'(gnt), 32'(onehot(exp_port)));
        req = '0;
        wait_idle("final_idle_timeout");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
